semaforo_input_conditioner: RTL and testbench
=============================================

# semaforo_input_conditioner

Conditions the two raw push-button inputs (set, change) from the GPIO pins before they reach the traffic-light controller. It synchronizes each input to the 10 kHz low-frequency clock, debounces it, and emits one-cycle press pulses and long-press pulses. It also provides clean debounced levels. It sits directly upstream of the semaforo block, in the same clklf domain.

## Interface
- DEBOUNCE_TICKS, 200: clklf cycles an input must stay stable before a level change is accepted (20 ms at 10 kHz); legal range 1..2^CNT_W-1
- LONG_PRESS_TICKS, 20000: clklf cycles the debounced press must be held to fire a long-press pulse (2 s); legal range 1..2^CNT_W-1
- CNT_W, 16: width of the debounce and hold counters
- clklf  in  1  10 kHz clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; clears every flop, including the synchronizers
- en  in  1  pulse enable; when low, all pulse outputs are forced to 0 while the FSMs keep running
- set_raw  in  1  raw set button, asynchronous, active-high
- change_raw  in  1  raw change button, asynchronous, active-high
- set_pulse  out  1  one-cycle pulse on an accepted set press
- change_pulse  out  1  one-cycle pulse on an accepted change press
- set_long  out  1  one-cycle pulse when a set press has been held LONG_PRESS_TICKS
- change_long  out  1  one-cycle pulse when a change press has been held LONG_PRESS_TICKS
- set_level  out  1  debounced set level
- change_level  out  1  debounced change level

## Operation
- Each channel has a 2-flop synchronizer (s1→s2). The FSM sees only s2.
- Per-channel FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE:
  - s2=1 → PRESS_WAIT, debounce count=0.
- PRESS_WAIT:
  - s2=0 → IDLE (bounce rejected, no output).
  - s2=1 and count==DEBOUNCE_TICKS-1 → PRESSED: level←1, press pulse, hold count←0.
  - Otherwise count+1.
- PRESSED:
  - s2=0 → RELEASE_WAIT, debounce count=0.
  - Otherwise hold count increments, saturating at LONG_PRESS_TICKS.
  - The long pulse fires only on the edge where hold count becomes LONG_PRESS_TICKS, so it fires at most once per press.
- RELEASE_WAIT:
  - s2=1 → PRESSED with no new pulse; hold count is kept, not reset.
  - s2=0 and count==DEBOUNCE_TICKS-1 → IDLE, level←0.
  - Otherwise count+1.
  - Hold count is frozen in this state.
- Pulses are registered outputs, high for exactly one cycle and ANDed with en at generation time.
  - A press that completes while en=0 is dropped, not queued.
  - Levels ignore en.
- Simultaneous events: if set_pulse and change_pulse would assert on the same edge, set_pulse asserts and change_pulse is suppressed for that press. set_long and change_long are independent.
- Reset values of all outputs: set_pulse=0, change_pulse=0, set_long=0, change_long=0, set_level=0, change_level=0. Both FSMs go to IDLE and all counters to 0.
- Reset mid-operation: any partial debounce is discarded. After reset deasserts, a still-held button restarts the full debounce sequence from IDLE.
- Counter comparisons are unsigned at CNT_W bits. Counters never wrap: the debounce counter is bounded by the state exit, and the hold counter saturates.

## Timing
- Press latency: with raw held high from before edge 1, s2=1 after edge 2, PRESS_WAIT after edge 3, and the pulse is high in the cycle after edge DEBOUNCE_TICKS+3. Total latency is DEBOUNCE_TICKS+3 cycles.
- Release latency: level falls DEBOUNCE_TICKS+3 cycles after raw falls.
- Long pulse: high in the cycle after the LONG_PRESS_TICKS-th edge spent in PRESSED.
- There is no combinational path from any input to any output.

## Structure
- Shared package/header semaforo_pkg holds:
  - the FSM state encodings (2-bit, IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3);
  - the default tick constants, derived from the 10 kHz clklf.
- Sub-module debounce_channel (synchronizer + FSM + counters + level/pulse/long outputs) is instantiated twice.
- The top level adds en gating and the set-over-change arbitration.

## Test plan
Bench parameters: DEBOUNCE_TICKS=4, LONG_PRESS_TICKS=10.
- Clean press: set_raw 0→1 held 30 cycles → set_pulse high for exactly 1 cycle, 7 cycles after the rise; set_level=1 from the same cycle.
- Bounce: change_raw high 3 cycles, low 2, high 3, then low → no change_pulse, change_level stays 0.
- Long hold: set_raw held 20 cycles past the pulse → set_long high once, 10 cycles after set_pulse. After release, set_level=0 after 7 cycles with no second pulse.
- Simultaneous: set_raw and change_raw rise on the same edge → set_pulse=1 and change_pulse=0; both levels=1.
- Enable gating: en=0 while the set press completes → set_pulse stays 0 and set_level=1. Raising en later while still held → still no pulse.
- Reset mid-debounce: reset asserted 2 cycles into PRESS_WAIT → all outputs 0 immediately. Release reset with raw still high → pulse 7 cycles after reset deasserts.

Source files
------------

// File: rtl/semaforo_pkg.sv
// rtl/semaforo_pkg.sv - shared state encodings and clklf-derived tick defaults
package semaforo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } chan_state_t;

  localparam int CLKLF_HZ      = 10000;
  localparam int DEBOUNCE_MS   = 20;
  localparam int LONG_PRESS_MS = 2000;

  localparam int DEF_DEBOUNCE_TICKS   = CLKLF_HZ / 1000 * DEBOUNCE_MS;
  localparam int DEF_LONG_PRESS_TICKS = CLKLF_HZ / 1000 * LONG_PRESS_MS;
  localparam int DEF_CNT_W            = 16;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: 2-flop synchronizer, debounce FSM, hold counter
module debounce_channel
  import semaforo_pkg::*;
#(
  parameter int DEBOUNCE_TICKS   = DEF_DEBOUNCE_TICKS,
  parameter int LONG_PRESS_TICKS = DEF_LONG_PRESS_TICKS,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic clklf,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_evt,
  output logic long_evt
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_PRESS_TICKS);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_TICKS - 1);

  logic             s1, s2;
  chan_state_t      state, state_nxt;
  logic [CNT_W-1:0] db_cnt, db_cnt_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             level_nxt;

  always_ff @(posedge clklf or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clklf or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      db_cnt   <= '0;
      hold_cnt <= '0;
      level    <= 1'b0;
    end else begin
      state    <= state_nxt;
      db_cnt   <= db_cnt_nxt;
      hold_cnt <= hold_cnt_nxt;
      level    <= level_nxt;
    end
  end

  // Hold count survives a release bounce so a re-press never re-arms the long pulse.
  always_comb begin
    state_nxt    = state;
    db_cnt_nxt   = db_cnt;
    hold_cnt_nxt = hold_cnt;
    level_nxt    = level;
    case (state)
      ST_IDLE: begin
        if (s2) begin
          state_nxt  = ST_PRESS_WAIT;
          db_cnt_nxt = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s2) begin
          state_nxt  = ST_IDLE;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt    = ST_PRESSED;
          level_nxt    = 1'b1;
          hold_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!s2) begin
          state_nxt  = ST_RELEASE_WAIT;
          db_cnt_nxt = '0;
        end else if (hold_cnt < HOLD_MAX) begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        if (s2) begin
          state_nxt = ST_PRESSED;
        end else if (db_cnt == DB_LAST) begin
          state_nxt = ST_IDLE;
          level_nxt = 1'b0;
        end else begin
          db_cnt_nxt = db_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    press_evt = (state == ST_PRESS_WAIT) && s2 && (db_cnt == DB_LAST);
    long_evt  = (state == ST_PRESSED) && s2 && (hold_cnt == HOLD_LAST);
  end

endmodule

// File: rtl/semaforo_input_conditioner.sv
// rtl/semaforo_input_conditioner.sv - set/change button conditioning with en gating and set priority
module semaforo_input_conditioner
  import semaforo_pkg::*;
#(
  parameter int DEBOUNCE_TICKS   = DEF_DEBOUNCE_TICKS,
  parameter int LONG_PRESS_TICKS = DEF_LONG_PRESS_TICKS,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic clklf,
  input  logic reset,
  input  logic en,
  input  logic set_raw,
  input  logic change_raw,
  output logic set_pulse,
  output logic change_pulse,
  output logic set_long,
  output logic change_long,
  output logic set_level,
  output logic change_level
);

  logic set_press, set_hold;
  logic change_press, change_hold;

  debounce_channel #(
    .DEBOUNCE_TICKS  (DEBOUNCE_TICKS),
    .LONG_PRESS_TICKS(LONG_PRESS_TICKS),
    .CNT_W           (CNT_W)
  ) u_set (
    .clklf    (clklf),
    .reset    (reset),
    .raw      (set_raw),
    .level    (set_level),
    .press_evt(set_press),
    .long_evt (set_hold)
  );

  debounce_channel #(
    .DEBOUNCE_TICKS  (DEBOUNCE_TICKS),
    .LONG_PRESS_TICKS(LONG_PRESS_TICKS),
    .CNT_W           (CNT_W)
  ) u_change (
    .clklf    (clklf),
    .reset    (reset),
    .raw      (change_raw),
    .level    (change_level),
    .press_evt(change_press),
    .long_evt (change_hold)
  );

  // A change press landing on the same edge as a set press is dropped, not deferred.
  always_ff @(posedge clklf or posedge reset) begin
    if (reset) begin
      set_pulse    <= 1'b0;
      change_pulse <= 1'b0;
      set_long     <= 1'b0;
      change_long  <= 1'b0;
    end else begin
      set_pulse    <= en & set_press;
      change_pulse <= en & change_press & ~set_press;
      set_long     <= en & set_hold;
      change_long  <= en & change_hold;
    end
  end

endmodule

// File: tb/tb_semaforo_input_conditioner.sv
// tb/tb_semaforo_input_conditioner.sv - vector table plus pulse scoreboard for the input conditioner
module tb_semaforo_input_conditioner;

  localparam int DB = 4;
  localparam int LP = 10;
  localparam int CW = 16;

  logic clklf = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic set_raw = 1'b0;
  logic change_raw = 1'b0;
  logic set_pulse, change_pulse, set_long, change_long, set_level, change_level;

  semaforo_input_conditioner #(
    .DEBOUNCE_TICKS  (DB),
    .LONG_PRESS_TICKS(LP),
    .CNT_W           (CW)
  ) dut (
    .clklf       (clklf),
    .reset       (reset),
    .en          (en),
    .set_raw     (set_raw),
    .change_raw  (change_raw),
    .set_pulse   (set_pulse),
    .change_pulse(change_pulse),
    .set_long    (set_long),
    .change_long (change_long),
    .set_level   (set_level),
    .change_level(change_level)
  );

  always #5 clklf = ~clklf;

  int cyc = 0;
  always @(posedge clklf) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    int   set_len;
    int   chg_len;
    logic en;
    int   sp;
    int   cp;
    int   sl;
    int   cl;
    logic s_lvl;
    logic c_lvl;
  } vec_t;
  vec_t vecs[11];

  function automatic string ev_name(input int k);
    case (k)
      0: return "set_pulse";
      1: return "change_pulse";
      2: return "set_long";
      default: return "change_long";
    endcase
  endfunction

  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic act, input logic req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0b required %0b", name, cyc, act, req);
    end
  endtask

  // Scoreboard: every observed pulse must match a queued expectation on the same cycle.
  always @(negedge clklf) begin
    logic [3:0] obs;
    bit found;
    obs = {change_long, set_long, change_pulse, set_pulse};
    for (int k = 0; k < 4; k++) begin
      if (obs[k] === 1'b1) begin
        found = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (!found && exp_q[i].kind == k && exp_q[i].at == cyc) begin
            exp_q.delete(i);
            found = 1'b1;
          end
        end
        compared++;
        if (!found) begin
          mismatched++;
          $display("FAIL %s unexpected at cycle %0d: got 1 required 0", ev_name(k), cyc);
        end
      end
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].at < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL %s missed at cycle %0d: got 0 required 1", ev_name(exp_q[i].kind), exp_q[i].at);
        exp_q.delete(i);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int k, n;
    en = v.en;
    set_raw = (v.set_len > 0);
    change_raw = (v.chg_len > 0);
    k = cyc;
    if (v.sp >= 0) expect_ev(0, k + v.sp);
    if (v.cp >= 0) expect_ev(1, k + v.cp);
    if (v.sl >= 0) expect_ev(2, k + v.sl);
    if (v.cl >= 0) expect_ev(3, k + v.cl);
    n = ((v.set_len > v.chg_len) ? v.set_len : v.chg_len) + 12;
    for (int t = 1; t <= n; t++) begin
      @(posedge clklf);
      #1;
      if (t == v.set_len) set_raw = 1'b0;
      if (t == v.chg_len) change_raw = 1'b0;
      @(negedge clklf);
      if (t == 8) begin
        check("set_level_after_debounce", set_level, v.s_lvl);
        check("change_level_after_debounce", change_level, v.c_lvl);
      end
      if (v.set_len > 0 && v.s_lvl && t == v.set_len + 6) check("set_level_before_release", set_level, 1'b1);
      if (v.set_len > 0 && t == v.set_len + 7) check("set_level_after_release", set_level, 1'b0);
      if (v.chg_len > 0 && v.c_lvl && t == v.chg_len + 6) check("change_level_before_release", change_level, 1'b1);
      if (v.chg_len > 0 && t == v.chg_len + 7) check("change_level_after_release", change_level, 1'b0);
    end
    en = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_set_pulse"}, set_pulse, 1'b0);
    check({name, "_change_pulse"}, change_pulse, 1'b0);
    check({name, "_set_long"}, set_long, 1'b0);
    check({name, "_change_long"}, change_long, 1'b0);
    check({name, "_set_level"}, set_level, 1'b0);
    check({name, "_change_level"}, change_level, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    // {set_len, chg_len, en, set_pulse@, change_pulse@, set_long@, change_long@, set_lvl, chg_lvl}
    vecs[0]  = '{30,  0, 1'b1,  7, -1, 17, -1, 1'b1, 1'b0};
    vecs[1]  = '{ 0, 30, 1'b1, -1,  7, -1, 17, 1'b0, 1'b1};
    vecs[2]  = '{30, 30, 1'b1,  7, -1, 17, 17, 1'b1, 1'b1};
    vecs[3]  = '{30,  0, 1'b0, -1, -1, -1, -1, 1'b1, 1'b0};
    vecs[4]  = '{ 4,  0, 1'b1, -1, -1, -1, -1, 1'b0, 1'b0};
    vecs[5]  = '{ 5,  0, 1'b1,  7, -1, -1, -1, 1'b1, 1'b0};
    vecs[6]  = '{14,  0, 1'b1,  7, -1, -1, -1, 1'b1, 1'b0};
    vecs[7]  = '{15,  0, 1'b1,  7, -1, 17, -1, 1'b1, 1'b0};
    vecs[8]  = '{30, 10, 1'b1,  7, -1, 17, -1, 1'b1, 1'b1};
    vecs[9]  = '{ 0,  6, 1'b1, -1,  7, -1, -1, 1'b0, 1'b1};
    vecs[10] = '{ 0, 30, 1'b0, -1, -1, -1, -1, 1'b0, 1'b1};

    repeat (3) @(posedge clklf);
    @(negedge clklf);
    check_all_zero("reset");
    @(posedge clklf);
    #1;
    reset = 1'b0;
    en = 1'b1;
    repeat (2) @(negedge clklf);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Bounce: 3 high, 2 low, 3 high never satisfies 4 stable ticks.
    change_raw = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clklf);
      #1;
      if (t == 3) change_raw = 1'b0;
      if (t == 5) change_raw = 1'b1;
      if (t == 8) change_raw = 1'b0;
      @(negedge clklf);
      check("bounce_change_level", change_level, 1'b0);
    end

    // Enable raised mid-hold: press pulse is lost, later long pulse is not.
    en = 1'b0;
    set_raw = 1'b1;
    k = cyc;
    expect_ev(2, k + 17);
    for (int t = 1; t <= 40; t++) begin
      @(posedge clklf);
      #1;
      if (t == 10) en = 1'b1;
      if (t == 25) set_raw = 1'b0;
      @(negedge clklf);
      if (t == 8) check("gated_set_level_high", set_level, 1'b1);
      if (t == 32) check("gated_set_level_low", set_level, 1'b0);
    end

    // Reset two cycles into the set PRESS_WAIT while change is already pressed.
    en = 1'b1;
    change_raw = 1'b1;
    k = cyc;
    expect_ev(1, k + 7);
    for (int t = 1; t <= 15; t++) begin
      @(posedge clklf);
      #1;
      if (t == 10) set_raw = 1'b1;
      if (t == 15) reset = 1'b1;
      if (t < 15) begin
        @(negedge clklf);
        if (t == 12) check("pre_reset_change_level", change_level, 1'b1);
      end
    end
    #1;
    check_all_zero("async_reset");
    repeat (3) @(posedge clklf);
    #1;
    reset = 1'b0;
    k = cyc;
    expect_ev(0, k + 7);
    expect_ev(2, k + 17);
    expect_ev(3, k + 17);
    for (int t = 1; t <= 40; t++) begin
      @(posedge clklf);
      #1;
      if (t == 25) begin
        set_raw = 1'b0;
        change_raw = 1'b0;
      end
      @(negedge clklf);
      if (t == 6) check("post_reset_set_level_still_low", set_level, 1'b0);
      if (t == 7) begin
        check("post_reset_set_level", set_level, 1'b1);
        check("post_reset_change_level", change_level, 1'b1);
      end
    end

    repeat (5) @(negedge clklf);
    foreach (exp_q[i]) begin
      compared++;
      mismatched++;
      $display("FAIL %s missed at cycle %0d: got 0 required 1", ev_name(exp_q[i].kind), exp_q[i].at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
